// File: rtl/attn_core.sv
// attn_core: small Q*K^T score engine with command interface.
//
// Holds three row memories (Q, K, psum), each 2**ADDR_W rows deep.
// A RUN multiplies one Q row against K rows 0..COL-1 through a two-stage
// pipeline (registered products, registered sign-extended sum) and writes
// the COL resulting lanes back as one psum row.
//
// Ports
//   clk, reset         single rising-edge clock, async active-low reset
//   cmd_valid/ready    command handshake, ready only while idle
//   cmd_op, cmd_addr   opcode (0 NOP, 1 WRQ, 2 WRK, 3 RUN, 4 RD, 5 NORM) and row
//   mem_in             write data for WRQ/WRK, element i at [i*BW +: BW]
//   out, out_valid     psum row returned by RD, lane j at [j*BW_PSUM +: BW_PSUM]
//   sum_out, sum_valid sum of lane magnitudes returned by NORM
//   done               one-cycle pulse when a RUN has written its psum row
//   err                sticky flag, set by an illegal opcode
//
// Build option
//   ATTN_CORE_NORM_EN  enables the NORM opcode; when undefined opcode 5 is
//                      treated as illegal and sum_out/sum_valid read 0.
//
// state | meaning
// IDLE  | accepting commands
// RUN   | issuing one K row per cycle into the product stage
// DRAIN | letting the last two pipeline stages settle
// WB    | writing the staged lanes to psum
// NORM  | two-cycle magnitude reduction of one psum row
module attn_core #(
    parameter int BW      = 8,
    parameter int PR      = 8,
    parameter int COL     = 8,
    parameter int ADDR_W  = 4,
    parameter int BW_PSUM = 2*BW+4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd_op,
    input  logic [ADDR_W-1:0]              cmd_addr,
    input  logic [PR*BW-1:0]               mem_in,
    output logic [COL*BW_PSUM-1:0]         out,
    output logic                           out_valid,
    output logic [BW_PSUM+$clog2(COL)-1:0] sum_out,
    output logic                           sum_valid,
    output logic                           done,
    output logic                           err
);

    localparam int DEPTH     = 1 << ADDR_W;
    localparam int DRAIN_LEN = 2;

    generate
        if (COL > DEPTH) begin : g_bad_cfg
            $error("attn_core: COL must not exceed 2**ADDR_W");
        end
    endgenerate

`ifdef ATTN_CORE_NORM_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WB, S_NORM} state_t;

    state_t state, state_nxt;

    logic [PR*BW-1:0]       qmem  [DEPTH];
    logic [PR*BW-1:0]       kmem  [DEPTH];
    logic [COL*BW_PSUM-1:0] psum  [DEPTH];

    logic accept, op_wrq, op_wrk, op_run, op_rd, op_norm, op_ill;
    logic issue, wb, issue_last, norm_ph;

    logic [ADDR_W-1:0]      issue_idx;
    logic [1:0]             drain_cnt;
    logic [PR*BW-1:0]       q_row;
    logic [PR*BW-1:0]       k_row;
    logic [ADDR_W-1:0]      tgt_addr;
    logic                   prod_vld;
    logic [ADDR_W-1:0]      prod_lane;
    logic signed [2*BW-1:0] prod_nxt [PR];
    logic signed [2*BW-1:0] prod_q   [PR];
    logic signed [BW_PSUM-1:0] dot_sum;
    logic [COL*BW_PSUM-1:0] staging;

    assign accept  = cmd_valid && cmd_ready;
    assign op_wrq  = accept && (cmd_op == 3'd1);
    assign op_wrk  = accept && (cmd_op == 3'd2);
    assign op_run  = accept && (cmd_op == 3'd3);
    assign op_rd   = accept && (cmd_op == 3'd4);
    assign op_norm = accept && (cmd_op == 3'd5) && NORM_EN;
    assign op_ill  = accept && ((cmd_op >= 3'd6) || ((cmd_op == 3'd5) && !NORM_EN));

    assign issue_last = (issue_idx == ADDR_W'(COL-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (op_run) state_nxt = S_RUN;
                     else if (op_norm) state_nxt = S_NORM;
            S_RUN:   if (issue_last) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd0) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            S_NORM:  if (norm_ph) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        issue     = (state == S_RUN);
        wb        = (state == S_WB);
    end

    // Memories carry no reset; psum is only touched in WB, so a reset
    // anywhere in RUN/DRAIN leaves the target row untouched.
    always_ff @(posedge clk) begin
        if (op_wrq) qmem[cmd_addr] <= mem_in;
        if (op_wrk) kmem[cmd_addr] <= mem_in;
        if (wb)     psum[tgt_addr] <= staging;
    end

    assign k_row = kmem[issue_idx];

    always_comb begin
        for (int i = 0; i < PR; i++)
            prod_nxt[i] = $signed(q_row[i*BW +: BW]) * $signed(k_row[i*BW +: BW]);
    end

    // Sign-extend each product to lane width; overflow wraps in the lane.
    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < PR; i++)
            dot_sum = dot_sum + BW_PSUM'(prod_q[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_idx <= '0;
            drain_cnt <= '0;
            q_row     <= '0;
            tgt_addr  <= '0;
            prod_vld  <= 1'b0;
            prod_lane <= '0;
            for (int i = 0; i < PR; i++) prod_q[i] <= '0;
            staging   <= '0;
            done      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (op_run) begin
                q_row     <= qmem[cmd_addr];
                tgt_addr  <= cmd_addr;
                issue_idx <= '0;
            end else if (issue) begin
                issue_idx <= issue_idx + 1'b1;
            end

            prod_vld <= issue;
            if (issue) begin
                prod_lane <= issue_idx;
                for (int i = 0; i < PR; i++) prod_q[i] <= prod_nxt[i];
            end

            if (prod_vld)
                staging[int'(prod_lane)*BW_PSUM +: BW_PSUM] <= dot_sum;

            if (issue && issue_last)
                drain_cnt <= 2'(DRAIN_LEN-1);
            else if ((state == S_DRAIN) && (drain_cnt != 2'd0))
                drain_cnt <= drain_cnt - 1'b1;

            done      <= wb;
            out_valid <= op_rd;
            if (op_rd) out <= psum[cmd_addr];
            if (op_ill) err <= 1'b1;
        end
    end

`ifdef ATTN_CORE_NORM_EN
    localparam int SUM_W = BW_PSUM + $clog2(COL);

    logic [COL*BW_PSUM-1:0] norm_row;
    logic                   norm_ph_q;
    logic [BW_PSUM-1:0]     lane_v, lane_mag;
    logic [SUM_W-1:0]       mag_sum;

    // Magnitude taken as unsigned, so the most-negative lane maps to 2**(BW_PSUM-1).
    always_comb begin
        lane_v   = '0;
        lane_mag = '0;
        mag_sum  = '0;
        for (int j = 0; j < COL; j++) begin
            lane_v   = norm_row[j*BW_PSUM +: BW_PSUM];
            lane_mag = lane_v[BW_PSUM-1] ? BW_PSUM'(-lane_v) : lane_v;
            mag_sum  = mag_sum + SUM_W'(lane_mag);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            norm_row  <= '0;
            norm_ph_q <= 1'b0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else begin
            if (op_norm) begin
                norm_row  <= psum[cmd_addr];
                norm_ph_q <= 1'b0;
            end else if (state == S_NORM) begin
                norm_ph_q <= 1'b1;
            end
            sum_valid <= (state == S_NORM) && norm_ph_q;
            if ((state == S_NORM) && norm_ph_q) sum_out <= mag_sum;
        end
    end

    assign norm_ph = norm_ph_q;
`else
    assign sum_out   = '0;
    assign sum_valid = 1'b0;
    assign norm_ph   = 1'b1;
`endif

endmodule
